// File: rtl/bcd_bin.sv
`timescale 1ns/1ps
// bcd_bin -- sequential packed-BCD to binary converter (reverse double-dabble).
//
// Converts an operator-entered decimal value, DIGITS packed BCD digits, into
// binary. Each iteration shifts {bcd_sr, bin_sr} right by one bit. Every BCD
// digit that is then >= 8 has 3 subtracted from it. After BIN_W iterations,
// bin_sr holds the binary value and bcd_sr has drained to zero.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    conversion request, honoured only while idle
//   bcd      packed BCD input, digit 0 in bits [3:0], sampled with start
//   bin      converted value, registered and held until the next completion
//   busy     high while a conversion is iterating
//   done     one-cycle pulse when bin/err are updated
//   err      set when an input digit was > 9 (bin forced to 0), held with bin
module bcd_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BIN_W-1:0]   bin_sr;
  logic [CNT_W-1:0]   cnt;
  logic               err_pend;

  logic [BCD_W-1:0]   bcd_nxt;
  logic [BIN_W-1:0]   bin_nxt;

  // Any nibble above 9 makes the whole input invalid.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Per-digit correction after the shift. Each digit is an independent 4-bit
  // subtract, so no borrow ever crosses a digit boundary.
  function automatic logic [BCD_W-1:0] dabble_fix(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  // The bit leaving the bottom of bcd_sr enters the top of bin_sr.
  assign bin_nxt = {bcd_sr[0], bin_sr[BIN_W-1:1]};
  assign bcd_nxt = dabble_fix({1'b0, bcd_sr[BCD_W-1:1]});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bcd_sr   <= '0;
      bin_sr   <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      bin      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            bin_sr <= '0;
            if (has_bad_digit(bcd)) begin
              // Skip the iterations entirely; FIN publishes err with bin=0.
              bcd_sr   <= '0;
              err_pend <= 1'b1;
              state    <= FIN;
            end else begin
              bcd_sr   <= bcd;
              err_pend <= 1'b0;
              busy     <= 1'b1;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          bcd_sr <= bcd_nxt;
          bin_sr <= bin_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_IT) state <= FIN;
        end
        FIN: begin
          bin   <= err_pend ? '0 : bin_sr;
          err   <= err_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_bin.sv
`timescale 1ns/1ps
module tb_bcd_bin;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp;
  int n_bad;

  bcd_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bcd     (bcd),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic logic bcd_invalid(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[3:0] > 4'd9) return 1'b1;
      t = t >> 4;
    end
    return 1'b0;
  endfunction

  function automatic int bcd_value(input logic [15:0] v);
    int acc;
    acc = 0;
    acc = acc + 1000 * int'(v[15:12]);
    acc = acc + 100  * int'(v[11:8]);
    acc = acc + 10   * int'(v[7:4]);
    acc = acc + int'(v[3:0]);
    return acc;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start, scrambles bcd after the start edge, waits (bounded) for
  // done and reports what the DUT produced plus timing/stability observations.
  task automatic run_conv(input logic [15:0] v, input logic [15:0] scramble,
                          output logic [13:0] rbin, output logic rerr,
                          output int lat, output int bcyc,
                          output logic stable_ok, output logic pulse_ok);
    logic [13:0] old_bin;
    logic        old_err;
    old_bin   = bin;
    old_err   = err;
    stable_ok = 1'b1;
    bcd   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bcd   = scramble;
    lat   = 0;
    bcyc  = busy ? 1 : 0;
    if (bin !== old_bin || err !== old_err) stable_ok = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (busy === 1'b1) bcyc++;
      if (done !== 1'b1 && (bin !== old_bin || err !== old_err)) stable_ok = 1'b0;
    end
    rbin = bin;
    rerr = err;
    tick();
    pulse_ok = (done === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    bcd     = 16'h0000;
    #2;
    n_cmp++;
    if ({bin, busy, done, err} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_state: got bin=%h busy=%b done=%b err=%b, want all 0", bin, busy, done, err);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({bin, busy, done, err} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_release: got bin=%h busy=%b done=%b err=%b, want all 0", bin, busy, done, err);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vals [6];
    int          exps [6];
    logic [13:0] rb;
    logic        re, st, po;
    int          lat, bc;
    vals = '{16'h0017, 16'h0255, 16'h8191, 16'h9999, 16'h0000, 16'h1000};
    exps = '{17, 255, 8191, 9999, 0, 1000};
    for (int k = 0; k < 6; k++) begin
      run_conv(vals[k], 16'(~vals[k]), rb, re, lat, bc, st, po);
      n_cmp++;
      if (rb !== 14'(exps[k]) || re !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_value %h: got bin=%0d err=%b, want bin=%0d err=0", vals[k], rb, re, exps[k]);
      end
      n_cmp++;
      if (lat !== 15) begin
        n_bad++;
        $display("FAIL directed_latency %h: got %0d, want 15", vals[k], lat);
      end
      n_cmp++;
      if (bc !== 15) begin
        n_bad++;
        $display("FAIL directed_busy %h: got %0d busy cycles, want 15", vals[k], bc);
      end
      n_cmp++;
      if (st !== 1'b1 || po !== 1'b1) begin
        n_bad++;
        $display("FAIL directed_hold %h: got stable=%b single_pulse=%b, want 1/1", vals[k], st, po);
      end
    end
  endtask

  task automatic test_invalid();
    logic [13:0] rb;
    logic        re, st, po;
    int          lat, bc;
    run_conv(16'h0A12, 16'h0000, rb, re, lat, bc, st, po);
    n_cmp++;
    if (rb !== 14'd0 || re !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_result: got bin=%0d err=%b, want bin=0 err=1", rb, re);
    end
    n_cmp++;
    if (lat !== 1 || bc !== 0 || po !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_timing: got lat=%0d busy=%0d pulse=%b, want 1/0/1", lat, bc, po);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_err_held: got err=%b, want 1", err);
    end
    run_conv(16'h0042, 16'h0A12, rb, re, lat, bc, st, po);
    n_cmp++;
    if (rb !== 14'd42 || re !== 1'b0 || lat !== 15) begin
      n_bad++;
      $display("FAIL after_invalid: got bin=%0d err=%b lat=%0d, want 42/0/15", rb, re, lat);
    end
    n_cmp++;
    if (st !== 1'b1) begin
      n_bad++;
      $display("FAIL after_invalid_hold: got stable=%b, want 1 (err/bin held until done)", st);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    reset_n = 1'b0;
    start   = 1'b1;
    bcd     = 16'h1234;
    tick();
    reset_n = 1'b1;
    pulses  = 0;
    last    = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      tick();
      if (cyc == 3) bcd = 16'h5678;
      if (cyc == 9) bcd = 16'h1234;
      if (done === 1'b1) begin
        pulses++;
        n_cmp++;
        if (bin !== 14'd1234 || err !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_value cyc %0d: got bin=%0d err=%b, want 1234/0", cyc, bin, err);
        end
        n_cmp++;
        if (cyc - last !== 16) begin
          n_bad++;
          $display("FAIL b2b_period cyc %0d: got gap %0d, want 16", cyc, cyc - last);
        end
        last = cyc;
      end
    end
    n_cmp++;
    if (pulses !== 4) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d done pulses, want 4", pulses);
    end
    start = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_reset_mid();
    int          dcount;
    logic [13:0] rb;
    logic        re, st, po;
    int          lat, bc;
    bcd   = 16'h5000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bin, busy, done, err} !== 17'd0) begin
      n_bad++;
      $display("FAIL midreset_clear: got bin=%0d busy=%b done=%b err=%b, want all 0", bin, busy, done, err);
    end
    tick();
    reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    n_cmp++;
    if (dcount !== 0) begin
      n_bad++;
      $display("FAIL midreset_no_done: got %0d done/busy cycles, want 0", dcount);
    end
    run_conv(16'h0099, 16'h5000, rb, re, lat, bc, st, po);
    n_cmp++;
    if (rb !== 14'd99 || re !== 1'b0 || lat !== 15) begin
      n_bad++;
      $display("FAIL midreset_next: got bin=%0d err=%b lat=%0d, want 99/0/15", rb, re, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [13:0] rb;
    logic        re, st, po;
    int          lat, bc;
    logic        inv;
    int          ebin;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else v = to_bcd(int'($urandom_range(0, 9999)));
      inv  = bcd_invalid(v);
      ebin = inv ? 0 : bcd_value(v);
      run_conv(v, 16'($urandom), rb, re, lat, bc, st, po);
      n_cmp++;
      if (rb !== 14'(ebin) || re !== inv || lat !== (inv ? 1 : 15)) begin
        n_bad++;
        $display("FAIL random %h: got bin=%0d err=%b lat=%0d, want %0d/%b/%0d",
                 v, rb, re, lat, ebin, inv, inv ? 1 : 15);
      end
    end
  endtask

  task automatic test_sweep();
    int          off;
    logic [13:0] rb;
    logic        re, st, po;
    int          lat, bc;
    off = int'($urandom_range(0, 3));
    for (int v = off; v < 10000; v += 4) begin
      run_conv(to_bcd(v), 16'($urandom), rb, re, lat, bc, st, po);
      n_cmp++;
      if (rb !== 14'(v) || re !== 1'b0 || lat !== 15) begin
        n_bad++;
        $display("FAIL sweep %0d: got bin=%0d err=%b lat=%0d, want %0d/0/15", v, rb, re, lat, v);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    bcd     = 16'h0000;
    test_reset();
    test_directed();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
